alu: RTL and testbench

- 16-bit registered ALU with 16 operations selected by a 4-bit function code: arithmetic, logic, compare and shift.
- Result and a one-hot operation-class flag set are captured on the rising clock edge.
- Sits in the processor execute stage. It is purely a datapath block: no handshake and no internal state beyond the output registers.

---
 rtl/alu_pkg.sv | 67 ++++++
 rtl/alu_if.sv | 24 ++
 rtl/alu_datapath.sv | 47 ++++
 rtl/alu.sv | 44 ++++
 tb/tb_alu.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, compare constants and operation-class helpers for the ALU.
// Imported by the datapath and the output-register top level.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MUL  = 4'b0010;
    localparam logic [3:0] ALU_DIV  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_NAND = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_XNOR = 4'b1001;
    localparam logic [3:0] ALU_EQ   = 4'b1010;
    localparam logic [3:0] ALU_GT   = 4'b1011;
    localparam logic [3:0] ALU_LT   = 4'b1100;
    localparam logic [3:0] ALU_SHR  = 4'b1101;
    localparam logic [3:0] ALU_SHL  = 4'b1110;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    localparam int CMP_EQ_VAL = 1;
    localparam int CMP_GT_VAL = 2;
    localparam int CMP_LT_VAL = 3;

    typedef enum logic [2:0] {
        CLASS_NONE,
        CLASS_ARITH,
        CLASS_LOGIC,
        CLASS_CMP,
        CLASS_SHIFT
    } op_class_t;

    typedef struct packed {
        logic arith;
        logic logic_op;
        logic cmp;
        logic shift;
    } alu_flags_t;

    // NOP and any unknown code fall into CLASS_NONE, which clears every flag.
    function automatic op_class_t op_class(input logic [3:0] func);
        op_class_t cls;
        case (func)
            ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV:                  cls = CLASS_ARITH;
            ALU_AND, ALU_OR, ALU_NAND, ALU_NOR, ALU_XOR, ALU_XNOR: cls = CLASS_LOGIC;
            ALU_EQ, ALU_GT, ALU_LT:                              cls = CLASS_CMP;
            ALU_SHR, ALU_SHL:                                    cls = CLASS_SHIFT;
            default:                                             cls = CLASS_NONE;
        endcase
        return cls;
    endfunction

    function automatic alu_flags_t flags_of(input op_class_t cls);
        alu_flags_t f;
        f = '0;
        case (cls)
            CLASS_ARITH: f.arith    = 1'b1;
            CLASS_LOGIC: f.logic_op = 1'b1;
            CLASS_CMP:   f.cmp      = 1'b1;
            CLASS_SHIFT: f.shift    = 1'b1;
            default:     f          = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the execute stage and the ALU.
// The ALU uses the slave modport; the issuing stage (or bench) uses master.
interface alu_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Function;
    logic [WIDTH-1:0] ALU_OUT;
    logic             Arith_flag;
    logic             Logic_flag;
    logic             CMP_flag;
    logic             Shift_flag;

    modport master (
        output A, B, ALU_Function,
        input  ALU_OUT, Arith_flag, Logic_flag, CMP_flag, Shift_flag
    );

    modport slave (
        input  A, B, ALU_Function,
        output ALU_OUT, Arith_flag, Logic_flag, CMP_flag, Shift_flag
    );
endinterface

// File: rtl/alu_datapath.sv
// Combinational ALU core: next result and next one-hot class flags.
// Define ALU_MULDIV_EN to build the multiplier and divider; otherwise MUL/DIV return 0.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_function,
    output logic [WIDTH-1:0] result_d,
    output alu_flags_t       flags_d
);

    always_comb begin
        result_d = '0;
        case (alu_function)
            ALU_ADD:  result_d = a + b;
            ALU_SUB:  result_d = a - b;
`ifdef ALU_MULDIV_EN
            ALU_MUL:  result_d = a * b;
            // Divide-by-zero saturates to all ones rather than leaving the quotient undefined.
            ALU_DIV:  result_d = (b == '0) ? '1 : (a / b);
`else
            ALU_MUL:  result_d = '0;
            ALU_DIV:  result_d = '0;
`endif
            ALU_AND:  result_d = a & b;
            ALU_OR:   result_d = a | b;
            ALU_NAND: result_d = ~(a & b);
            ALU_NOR:  result_d = ~(a | b);
            ALU_XOR:  result_d = a ^ b;
            ALU_XNOR: result_d = ~(a ^ b);
            ALU_EQ:   result_d = (a == b) ? WIDTH'(CMP_EQ_VAL) : '0;
            ALU_GT:   result_d = (a > b)  ? WIDTH'(CMP_GT_VAL) : '0;
            ALU_LT:   result_d = (a < b)  ? WIDTH'(CMP_LT_VAL) : '0;
            ALU_SHR:  result_d = {1'b0, a[WIDTH-1:1]};
            ALU_SHL:  result_d = {a[WIDTH-2:0], 1'b0};
            default:  result_d = '0;
        endcase
    end

    always_comb begin
        flags_d = flags_of(op_class(alu_function));
    end

endmodule

// File: rtl/alu.sv
// Registered 16-operation ALU: result and class flags captured every rising edge.
// Multiply/divide present only when ALU_MULDIV_EN is defined (see alu_datapath).
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);

    logic [WIDTH-1:0] alu_out_d;
    logic [WIDTH-1:0] alu_out_q;
    alu_flags_t       flags_d;
    alu_flags_t       flags_q;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .a            (bus.A),
        .b            (bus.B),
        .alu_function (bus.ALU_Function),
        .result_d     (alu_out_d),
        .flags_d      (flags_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
            flags_q   <= '0;
        end else begin
            alu_out_q <= alu_out_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.ALU_OUT    = alu_out_q;
    assign bus.Arith_flag = flags_q.arith;
    assign bus.Logic_flag = flags_q.logic_op;
    assign bus.CMP_flag   = flags_q.cmp;
    assign bus.Shift_flag = flags_q.shift;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases, async reset, edge timing and
// randomized back-to-back traffic against an arithmetic reference model.
module tb_alu;

    localparam int W = 16;
    localparam int unsigned M = 65536;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_if #(.WIDTH(W)) bus ();

    alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic [15:0] exp;
    } vec_t;

`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    // Reference result from plain integer arithmetic on the opcode number.
    function automatic int unsigned ref_result(input int unsigned a, input int unsigned b, input int op);
        case (op)
            0:  return (a + b) % M;
            1:  return (a + M - b) % M;
            2:  return MULDIV ? (a * b) % M : 0;
            3:  return MULDIV ? ((b == 0) ? M - 1 : a / b) : 0;
            4:  return a & b;
            5:  return a | b;
            6:  return (M - 1) - (a & b);
            7:  return (M - 1) - (a | b);
            8:  return a ^ b;
            9:  return (M - 1) - (a ^ b);
            10: return (a == b) ? 1 : 0;
            11: return (a > b) ? 2 : 0;
            12: return (a < b) ? 3 : 0;
            13: return a / 2;
            14: return (a * 2) % M;
            default: return 0;
        endcase
    endfunction

    // Expected {Arith, Logic, CMP, Shift} from the opcode ranges.
    function automatic logic [3:0] ref_flags(input int op);
        if (op <= 3)       return 4'b1000;
        else if (op <= 9)  return 4'b0100;
        else if (op <= 12) return 4'b0010;
        else if (op <= 14) return 4'b0001;
        else               return 4'b0000;
    endfunction

    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        @(negedge clk);
        bus.A            = a;
        bus.B            = b;
        bus.ALU_Function = op;
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        bus.A            = 16'd5;
        bus.B            = 16'd10;
        bus.ALU_Function = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_out got %h expected 0000", bus.ALU_OUT);
        end
        n_checks++;
        if ({bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got %b expected 0000",
                     {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'd15) begin
            n_fail++;
            $display("[TB] FAIL first_capture got %h expected 000f", bus.ALU_OUT);
        end
    endtask

    task automatic test_arith();
        vec_t v[5];
        v[0] = '{16'd5,  16'd10, 4'b0000, 16'd15};
        v[1] = '{16'd16, 16'd12, 4'b0001, 16'd4};
        v[2] = '{16'd4,  16'd8,  4'b0010, MULDIV ? 16'd32   : 16'd0};
        v[3] = '{16'd12, 16'd2,  4'b0011, MULDIV ? 16'd6    : 16'd0};
        v[4] = '{16'd3,  16'd0,  4'b0011, MULDIV ? 16'hFFFF : 16'd0};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(v[i].a, v[i].b, v[i].op);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.ALU_OUT !== v[i].exp) begin
                n_fail++;
                $display("[TB] FAIL arith[%0d] out got %h expected %h", i, bus.ALU_OUT, v[i].exp);
            end
            n_checks++;
            if ({bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== 4'b1000) begin
                n_fail++;
                $display("[TB] FAIL arith[%0d] flags got %b expected 1000", i,
                         {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag});
            end
        end
    endtask

    task automatic test_logic();
        vec_t v[6];
        v[0] = '{16'd15, 16'd7, 4'b0100, 16'd7};
        v[1] = '{16'd15, 16'd7, 4'b0101, 16'd15};
        v[2] = '{16'd15, 16'd7, 4'b0110, 16'hFFF8};
        v[3] = '{16'd0,  16'd0, 4'b0111, 16'hFFFF};
        v[4] = '{16'd0,  16'd0, 4'b1000, 16'h0000};
        v[5] = '{16'd0,  16'd0, 4'b1001, 16'hFFFF};
        for (int i = 0; i < 6; i++) begin
            apply_stimulus(v[i].a, v[i].b, v[i].op);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.ALU_OUT !== v[i].exp) begin
                n_fail++;
                $display("[TB] FAIL logic[%0d] out got %h expected %h", i, bus.ALU_OUT, v[i].exp);
            end
            n_checks++;
            if ({bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== 4'b0100) begin
                n_fail++;
                $display("[TB] FAIL logic[%0d] flags got %b expected 0100", i,
                         {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag});
            end
        end
    endtask

    task automatic test_compare();
        vec_t v[4];
        v[0] = '{16'd5, 16'd5, 4'b1010, 16'd1};
        v[1] = '{16'd5, 16'd8, 4'b1011, 16'd0};
        v[2] = '{16'd5, 16'd8, 4'b1100, 16'd3};
        v[3] = '{16'd9, 16'd4, 4'b1011, 16'd2};
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(v[i].a, v[i].b, v[i].op);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.ALU_OUT !== v[i].exp) begin
                n_fail++;
                $display("[TB] FAIL cmp[%0d] out got %h expected %h", i, bus.ALU_OUT, v[i].exp);
            end
            n_checks++;
            if ({bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== 4'b0010) begin
                n_fail++;
                $display("[TB] FAIL cmp[%0d] flags got %b expected 0010", i,
                         {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag});
            end
        end
    endtask

    task automatic test_shift_nop();
        vec_t       v[4];
        logic [3:0] fexp[4];
        v[0] = '{16'd7,    16'hABCD, 4'b1101, 16'd3};
        v[1] = '{16'd7,    16'hABCD, 4'b1110, 16'd14};
        v[2] = '{16'd7,    16'hABCD, 4'b1111, 16'd0};
        v[3] = '{16'h8001, 16'h1234, 4'b1110, 16'h0002};
        fexp[0] = 4'b0001;
        fexp[1] = 4'b0001;
        fexp[2] = 4'b0000;
        fexp[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(v[i].a, v[i].b, v[i].op);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.ALU_OUT !== v[i].exp) begin
                n_fail++;
                $display("[TB] FAIL shift[%0d] out got %h expected %h", i, bus.ALU_OUT, v[i].exp);
            end
            n_checks++;
            if ({bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== fexp[i]) begin
                n_fail++;
                $display("[TB] FAIL shift[%0d] flags got %b expected %b", i,
                         {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag}, fexp[i]);
            end
        end
    endtask

    task automatic test_timing();
        apply_stimulus(16'd100, 16'd1, 4'b0001);
        @(posedge clk);
        #8;
        bus.A            = 16'h00F0;
        bus.B            = 16'h0FF0;
        bus.ALU_Function = 4'b0100;
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'd99 || bus.Arith_flag !== 1'b1 || bus.Logic_flag !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL timing_hold got out=%h arith=%b logic=%b expected out=0063 arith=1 logic=0",
                     bus.ALU_OUT, bus.Arith_flag, bus.Logic_flag);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'h00F0 || bus.Arith_flag !== 1'b0 || bus.Logic_flag !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL timing_update got out=%h arith=%b logic=%b expected out=00f0 arith=0 logic=1",
                     bus.ALU_OUT, bus.Arith_flag, bus.Logic_flag);
        end
    endtask

    task automatic test_async_reset();
        apply_stimulus(16'd5, 16'd10, 4'b0000);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'd15) begin
            n_fail++;
            $display("[TB] FAIL areset_pre got %h expected 000f", bus.ALU_OUT);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'h0000 ||
            {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL areset_clear got out=%h flags=%b expected out=0000 flags=0000", bus.ALU_OUT,
                     {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag});
        end
        bus.A            = 16'd9;
        bus.B            = 16'd4;
        bus.ALU_Function = 4'b1011;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'h0000 || bus.CMP_flag !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL areset_held got out=%h cmp=%b expected out=0000 cmp=0", bus.ALU_OUT, bus.CMP_flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.ALU_OUT !== 16'd2 ||
            {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== 4'b0010) begin
            n_fail++;
            $display("[TB] FAIL areset_release got out=%h flags=%b expected out=0002 flags=0010", bus.ALU_OUT,
                     {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b;
        int          op;
        int unsigned exp_r;
        logic [3:0]  exp_f;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            a  = 16'($urandom);
            op = int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0)      b = a;
            else if ($urandom_range(0, 7) == 0) b = 16'h0000;
            else                                b = 16'($urandom);
            bus.A            = a;
            bus.B            = b;
            bus.ALU_Function = 4'(op);
            exp_r = ref_result(int'(a), int'(b), op);
            exp_f = ref_flags(op);
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.ALU_OUT !== exp_r[15:0]) begin
                n_fail++;
                $display("[TB] FAIL rand[%0d] op=%0d a=%h b=%h out got %h expected %h",
                         i, op, a, b, bus.ALU_OUT, exp_r[15:0]);
            end
            n_checks++;
            if ({bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag} !== exp_f) begin
                n_fail++;
                $display("[TB] FAIL rand[%0d] op=%0d flags got %b expected %b", i, op,
                         {bus.Arith_flag, bus.Logic_flag, bus.CMP_flag, bus.Shift_flag}, exp_f);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_arith();
        test_logic();
        test_compare();
        test_shift_nop();
        test_timing();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
